stream_pattern_gen: RTL

STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

---
 rtl/stream_test_pkg.sv | 34 +++
 rtl/IPIF_parameterDecode.sv | 52 +++++
 rtl/prbs32_lfsr.sv | 26 ++
 rtl/stream_pattern_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stream_test_pkg.sv
// Shared types and constants for the stream pattern generator.
// Pure declarations, no timing.
// No flow control here.
package stream_test_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_PRBS    = 2'd1,
    MODE_FIXED   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Fibonacci tap mask for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Decoded view of the control registers
  typedef struct packed {
    logic [31:0] word_limit;
    logic [31:0] seed;
    mode_t       mode;
    logic        enable;
  } param_t;

  // One shift of the LFSR: shift left, feedback enters at bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_POLY)};
  endfunction

endpackage

// File: rtl/IPIF_parameterDecode.sv
// IPIF slave register file: byte-enabled writes, CE-selected readback mux.
// Acks are combinational in the same cycle as the chip enable.
// Never stalls the bus.
module IPIF_parameterDecode #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_REG              = 4
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic                                     cs,
  input  logic                                     rnw,
  input  logic [N_REG-1:0]                         rd_ce,
  input  logic [N_REG-1:0]                         wr_ce,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          be,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            wr_data,
  input  logic [N_REG-1:0][C_S_AXI_DATA_WIDTH-1:0] rd_regs,
  output logic [N_REG-1:0][C_S_AXI_DATA_WIDTH-1:0] regs,
  output logic [N_REG-1:0]                         wr_stb,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            rd_data,
  output logic                                     wr_ack,
  output logic                                     rd_ack
);

  logic [N_REG-1:0] rd_stb;

  assign wr_stb = wr_ce & {N_REG{cs & ~rnw}};
  assign rd_stb = rd_ce & {N_REG{cs & rnw}};
  assign wr_ack = |wr_stb;
  assign rd_ack = |rd_stb;

  // Byte-lane writes into the selected register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
          if (wr_stb[i] && be[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Readback mux; zero when nothing is selected
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (rd_stb[i]) rd_data = rd_data | rd_regs[i];
    end
  end

endmodule

// File: rtl/prbs32_lfsr.sv
// 32-bit Fibonacci LFSR with synchronous load; a zero seed is forced to 1.
// State updates one cycle after load/advance.
// No backpressure; caller decides when to advance.
module prbs32_lfsr
  import stream_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // Load has priority so a run always starts from the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= (seed == 32'd0) ? 32'd1 : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/stream_pattern_gen.sv
// AXI-Stream pattern source (counter / PRBS / fixed) with IPIF control.
// First word one cycle after enable is seen; one word per cycle while TREADY=1.
// Presented word and TLAST are held while TREADY=0; a word is never withdrawn.
module stream_pattern_gen
  import stream_test_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_REG              = 4,
  parameter int TDATA_WIDTH        = 32
) (
  input  logic                            clk,
  input  logic                            aresetn,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TLAST,
  input  logic                            IPIF_Bus2IP_resetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   IPIF_Bus2IP_Addr,
  input  logic                            IPIF_Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_Bus2IP_BE,
  input  logic                            IPIF_Bus2IP_CS,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_RdCE,
  input  logic [N_REG-1:0]                IPIF_Bus2IP_WrCE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_IP2Bus_Data,
  output logic                            IPIF_IP2Bus_WrAck,
  output logic                            IPIF_IP2Bus_RdAck,
  output logic                            IPIF_IP2Bus_Error
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int W  = TDATA_WIDTH;

  logic [N_REG-1:0][DW-1:0] regs, rd_regs;
  logic [N_REG-1:0]         wr_stb;
  param_t                   prm;

  logic        soft_q, rst_int, latch_p, inject_p;
  state_t      state_q, state_d;
  mode_t       mode_q;
  logic [31:0] limit_q, run_cnt, word_count, err_count, lat_wc, lat_err;
  logic [31:0] lfsr_state;
  logic [W-1:0] word_q, pattern;
  logic        xfer, load, advance, last_word;
  logic        inj_pend, inj_act, pend_eff;
  logic        unused_bits;

  IPIF_parameterDecode #(.C_S_AXI_DATA_WIDTH(DW), .N_REG(N_REG)) u_decode (
    .clk(clk), .resetn(IPIF_Bus2IP_resetn), .cs(IPIF_Bus2IP_CS), .rnw(IPIF_Bus2IP_RNW),
    .rd_ce(IPIF_Bus2IP_RdCE), .wr_ce(IPIF_Bus2IP_WrCE), .be(IPIF_Bus2IP_BE),
    .wr_data(IPIF_Bus2IP_Data), .rd_regs(rd_regs), .regs(regs), .wr_stb(wr_stb),
    .rd_data(IPIF_IP2Bus_Data), .wr_ack(IPIF_IP2Bus_WrAck), .rd_ack(IPIF_IP2Bus_RdAck)
  );

  assign IPIF_IP2Bus_Error = 1'b0;
  assign prm = '{word_limit: regs[3][31:0], seed: regs[2][31:0],
                 mode: mode_t'(regs[1][2:1]), enable: regs[1][0]};

  // reg0 is write-only: its bits act as one-cycle command pulses
  assign latch_p  = wr_stb[0] & IPIF_Bus2IP_Data[1];
  assign inject_p = wr_stb[0] & IPIF_Bus2IP_Data[2];

  // Register the soft reset so the async reset net is glitch-free
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) soft_q <= 1'b0;
    else          soft_q <= wr_stb[0] & IPIF_Bus2IP_Data[0];
  end
  assign rst_int = aresetn & ~soft_q;

  assign xfer      = (state_q == ST_RUN) & M_AXIS_TREADY;
  assign last_word = (limit_q != 32'd0) && (run_cnt == limit_q - 32'd1);

  // State register
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; a presented word always completes before leaving RUN
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: if (prm.enable) begin
        state_d = ST_RUN;
        load    = 1'b1;
      end
      ST_RUN: if (xfer) begin
        if (last_word)        state_d = ST_DONE;
        else if (!prm.enable) state_d = ST_IDLE;
        else                  advance = 1'b1;
      end
      ST_DONE: if (!prm.enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  prbs32_lfsr u_lfsr (
    .clk(clk), .rst_n(rst_int), .load(load), .seed(prm.seed),
    .advance(advance), .state(lfsr_state)
  );

  // Run settings are captured only at run start; counter/fixed word source
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      mode_q  <= MODE_COUNTER;
      limit_q <= '0;
      run_cnt <= '0;
      word_q  <= '0;
    end else if (load) begin
      mode_q  <= prm.mode;
      limit_q <= prm.word_limit;
      run_cnt <= '0;
      word_q  <= prm.seed[W-1:0];
    end else if (xfer) begin
      run_cnt <= run_cnt + 32'd1;
      if (advance && mode_q == MODE_COUNTER) word_q <= word_q + W'(1);
    end
  end

  // An injection attaches to the next word to be presented, so a stalled
  // word never changes; pulses arriving while one is outstanding are dropped
  assign pend_eff = inj_pend | (inject_p & ~inj_act);
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      inj_pend <= 1'b0;
      inj_act  <= 1'b0;
    end else if (load || advance) begin
      inj_act  <= pend_eff;
      inj_pend <= 1'b0;
    end else if (xfer) begin
      inj_act  <= 1'b0;
      inj_pend <= pend_eff;
    end else begin
      inj_pend <= pend_eff;
    end
  end

  // Saturating statistics and their latched snapshot
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      word_count <= '0;
      err_count  <= '0;
      lat_wc     <= '0;
      lat_err    <= '0;
    end else begin
      if (xfer && word_count != '1) word_count <= word_count + 32'd1;
      if (xfer && inj_act && err_count != '1) err_count <= err_count + 32'd1;
      if (latch_p) begin
        lat_wc  <= word_count;
        lat_err <= err_count;
      end
    end
  end

  assign pattern       = (mode_q == MODE_PRBS) ? lfsr_state[W-1:0] : word_q;
  assign M_AXIS_TVALID = (state_q == ST_RUN);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? (pattern ^ W'(inj_act)) : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID & last_word;

  // Readback: reg0 latched word_count, reg1 latched err_injected, others as written
  always_comb begin
    rd_regs = regs;
    rd_regs[0] = DW'(lat_wc);
    rd_regs[1] = DW'(lat_err);
  end

  assign unused_bits = ^{IPIF_Bus2IP_Addr, regs, lfsr_state};

endmodule
